led_timing_generator: RTL and testbench



---
 rtl/led_timing_pkg.sv | 19 +
 rtl/led_timing_generator_divider.sv | 32 +++
 rtl/led_timing_generator.sv | 163 ++++++++++++++++
 tb/tb_led_timing_generator.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_timing_pkg.sv
// Shared constants for the LED timing generator: default divider ratios,
// the default frame period and the smallest frame period the counter allows.
package led_timing_pkg;

  localparam int unsigned DEF_SEG_DIV           = 4;
  localparam int unsigned DEF_SEGS_PER_BIT      = 4;
  localparam int unsigned DEF_BITS_PER_LED      = 24;
  localparam int unsigned DEF_FRAME_W           = 20;
  localparam int unsigned DEF_FRAME_PERIOD_INIT = 200000;

  // A frame period of 0 or 1 would make the counter wrap degenerate.
  localparam int unsigned MIN_PERIOD = 2;

  // Width of an index that counts 0..n-1, never narrower than one bit.
  function automatic int unsigned index_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_timing_generator_divider.sv
// tick_divider: generic modulo-N counter used for each stage of the
// segment / bit / LED cascade. It advances only when 'advance' is high
// and wraps from N-1 back to 0; restart forces it back to 0.
module tick_divider
  import led_timing_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = index_width(N)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         restart,
  input  logic         advance,
  output logic [W-1:0] index
);

  logic last;

  assign last = (index == W'(N - 1));

  // Modulo-N count, held whenever the stage is not advanced.
  always_ff @(posedge clock) begin
    if (reset) begin
      index <= '0;
    end else if (restart) begin
      index <= '0;
    end else if (advance) begin
      index <= last ? '0 : index + W'(1);
    end
  end

endmodule

// File: rtl/led_timing_generator.sv
// led_timing_generator: divides the system clock into one-cycle enable
// strobes (segment, bit, LED word, frame) for the LED serial output path.
// Optional macro LED_TIMING_SQUARE_EN adds legacy square-wave outputs
// seg_clock, bit_clock, led_clock and framerate that toggle on each tick.
module led_timing_generator
  import led_timing_pkg::*;
#(
  parameter int unsigned SEG_DIV           = DEF_SEG_DIV,
  parameter int unsigned SEGS_PER_BIT      = DEF_SEGS_PER_BIT,
  parameter int unsigned BITS_PER_LED      = DEF_BITS_PER_LED,
  parameter int unsigned FRAME_W           = DEF_FRAME_W,
  parameter int unsigned FRAME_PERIOD_INIT = DEF_FRAME_PERIOD_INIT
) (
  input  logic                                   clock_12mhz,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic                                   restart,
  input  logic [FRAME_W-1:0]                     frame_period_in,
  input  logic                                   frame_period_load,
  output logic                                   seg_tick,
  output logic                                   bit_tick,
  output logic                                   led_tick,
  output logic                                   frame_tick,
  output logic [index_width(SEGS_PER_BIT)-1:0]   seg_index,
  output logic [index_width(BITS_PER_LED)-1:0]   bit_index,
  output logic [FRAME_W-1:0]                     frame_period,
  output logic                                   load_pending
`ifdef LED_TIMING_SQUARE_EN
  ,
  output logic                                   seg_clock,
  output logic                                   bit_clock,
  output logic                                   led_clock,
  output logic                                   framerate
`endif
);

  localparam int unsigned SEG_CNT_W = index_width(SEG_DIV);
  localparam int unsigned SEG_IDX_W = index_width(SEGS_PER_BIT);
  localparam int unsigned BIT_IDX_W = index_width(BITS_PER_LED);

  logic [SEG_CNT_W-1:0] seg_count;
  logic                 seg_last;
  logic                 seg_index_last;
  logic                 bit_index_last;
  logic                 seg_wrap;
  logic                 bit_wrap;
  logic                 led_wrap;

  logic [FRAME_W-1:0]   frame_count;
  logic [FRAME_W-1:0]   shadow;
  logic [FRAME_W-1:0]   staged;
  logic [FRAME_W-1:0]   shadow_next;
  logic                 frame_last;
  logic                 frame_wrap;

  // Each stage only moves when the stage below it wraps, so a higher-stage
  // wrap is always coincident with the lower-stage wrap that completes it.
  assign seg_last       = (seg_count == SEG_CNT_W'(SEG_DIV - 1));
  assign seg_index_last = (seg_index == SEG_IDX_W'(SEGS_PER_BIT - 1));
  assign bit_index_last = (bit_index == BIT_IDX_W'(BITS_PER_LED - 1));

  assign seg_wrap = enable & seg_last;
  assign bit_wrap = seg_wrap & seg_index_last;
  assign led_wrap = bit_wrap & bit_index_last;

  tick_divider #(.N(SEG_DIV), .W(SEG_CNT_W)) u_seg_stage (
    .clock   (clock_12mhz),
    .reset   (reset),
    .restart (restart),
    .advance (enable),
    .index   (seg_count)
  );

  tick_divider #(.N(SEGS_PER_BIT), .W(SEG_IDX_W)) u_bit_stage (
    .clock   (clock_12mhz),
    .reset   (reset),
    .restart (restart),
    .advance (seg_wrap),
    .index   (seg_index)
  );

  tick_divider #(.N(BITS_PER_LED), .W(BIT_IDX_W)) u_led_stage (
    .clock   (clock_12mhz),
    .reset   (reset),
    .restart (restart),
    .advance (bit_wrap),
    .index   (bit_index)
  );

  // Cascade strobes are registered copies of the stage wraps; enable low
  // makes every wrap 0, so the ticks drop for the whole hold.
  always_ff @(posedge clock_12mhz) begin
    if (reset || restart) begin
      seg_tick <= 1'b0;
      bit_tick <= 1'b0;
      led_tick <= 1'b0;
    end else begin
      seg_tick <= seg_wrap;
      bit_tick <= bit_wrap;
      led_tick <= led_wrap;
    end
  end

  // Loaded periods below the minimum are clamped before they are staged.
  assign staged      = (frame_period_in < FRAME_W'(MIN_PERIOD)) ? FRAME_W'(MIN_PERIOD)
                                                                : frame_period_in;
  assign shadow_next = frame_period_load ? staged : shadow;

  // The >= compare keeps the counter bounded even if it ever sat above the period.
  assign frame_last = (frame_count >= (frame_period - FRAME_W'(1)));
  assign frame_wrap = enable & frame_last;

  // Frame counter with shadowed period: the shadow only takes effect at a
  // wrap (so no runt frames) or immediately on restart. A load in the wrap
  // cycle stays pending because the wrap applies the previous shadow value.
  always_ff @(posedge clock_12mhz) begin
    if (reset) begin
      frame_count  <= '0;
      frame_tick   <= 1'b0;
      frame_period <= FRAME_W'(FRAME_PERIOD_INIT);
      shadow       <= FRAME_W'(FRAME_PERIOD_INIT);
      load_pending <= 1'b0;
    end else if (restart) begin
      frame_count  <= '0;
      frame_tick   <= 1'b0;
      frame_period <= shadow_next;
      shadow       <= shadow_next;
      load_pending <= 1'b0;
    end else begin
      shadow     <= shadow_next;
      frame_tick <= frame_wrap;
      if (frame_wrap) begin
        frame_count  <= '0;
        frame_period <= shadow;
      end else if (enable) begin
        frame_count <= frame_count + FRAME_W'(1);
      end
      if (frame_period_load) begin
        load_pending <= 1'b1;
      end else if (frame_wrap) begin
        load_pending <= 1'b0;
      end
    end
  end

`ifdef LED_TIMING_SQUARE_EN
  // Legacy clock-style outputs: each one flips on the edge its tick is raised.
  always_ff @(posedge clock_12mhz) begin
    if (reset || restart) begin
      seg_clock <= 1'b0;
      bit_clock <= 1'b0;
      led_clock <= 1'b0;
      framerate <= 1'b0;
    end else begin
      if (seg_wrap)   seg_clock <= ~seg_clock;
      if (bit_wrap)   bit_clock <= ~bit_clock;
      if (led_wrap)   led_clock <= ~led_clock;
      if (frame_wrap) framerate <= ~framerate;
    end
  end
`endif

endmodule

// File: tb/tb_led_timing_generator.sv
// Directed bench for led_timing_generator with default cascade ratios and a
// short initial frame period. Square-wave outputs are checked when
// LED_TIMING_SQUARE_EN is defined.
module tb_led_timing_generator;

  localparam int FRAME_W = 20;
  localparam int P0      = 600;

  logic               clock_12mhz = 1'b0;
  logic               reset;
  logic               enable;
  logic               restart;
  logic [FRAME_W-1:0] frame_period_in;
  logic               frame_period_load;
  logic               seg_tick;
  logic               bit_tick;
  logic               led_tick;
  logic               frame_tick;
  logic [1:0]         seg_index;
  logic [4:0]         bit_index;
  logic [FRAME_W-1:0] frame_period;
  logic               load_pending;
`ifdef LED_TIMING_SQUARE_EN
  logic               seg_clock;
  logic               bit_clock;
  logic               led_clock;
  logic               framerate;
`endif

  int total   = 0;
  int bad     = 0;
  int edge_no = 0;
  int k       = 0;
  bit adv     = 1'b0;

  led_timing_generator #(
    .SEG_DIV           (4),
    .SEGS_PER_BIT      (4),
    .BITS_PER_LED      (24),
    .FRAME_W           (FRAME_W),
    .FRAME_PERIOD_INIT (P0)
  ) dut (
    .clock_12mhz       (clock_12mhz),
    .reset             (reset),
    .enable            (enable),
    .restart           (restart),
    .frame_period_in   (frame_period_in),
    .frame_period_load (frame_period_load),
    .seg_tick          (seg_tick),
    .bit_tick          (bit_tick),
    .led_tick          (led_tick),
    .frame_tick        (frame_tick),
    .seg_index         (seg_index),
    .bit_index         (bit_index),
    .frame_period      (frame_period),
    .load_pending      (load_pending)
`ifdef LED_TIMING_SQUARE_EN
    ,
    .seg_clock         (seg_clock),
    .bit_clock         (bit_clock),
    .led_clock         (led_clock),
    .framerate         (framerate)
`endif
  );

  always #5 clock_12mhz = ~clock_12mhz;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  // One clock edge; k counts enabled edges since the last reset/restart.
  task automatic step();
    adv = enable && !restart && !reset;
    if (reset || restart) k = 0;
    else if (adv) k++;
    @(posedge clock_12mhz);
    #1;
    edge_no++;
  endtask

  task automatic checkCascade(input string ctx, input int fp);
    checkOutput({ctx, " seg_tick"},  seg_tick,  32'(adv && (k % 4 == 0)));
    checkOutput({ctx, " bit_tick"},  bit_tick,  32'(adv && (k % 16 == 0)));
    checkOutput({ctx, " led_tick"},  led_tick,  32'(adv && (k % 384 == 0)));
    checkOutput({ctx, " seg_index"}, seg_index, (k / 4) % 4);
    checkOutput({ctx, " bit_index"}, bit_index, (k / 16) % 24);
    if (fp > 0) checkOutput({ctx, " frame_tick"}, frame_tick, 32'(adv && (k % fp == 0)));
`ifdef LED_TIMING_SQUARE_EN
    checkOutput({ctx, " seg_clock"}, seg_clock, (k / 4) % 2);
    checkOutput({ctx, " bit_clock"}, bit_clock, (k / 16) % 2);
    checkOutput({ctx, " led_clock"}, led_clock, (k / 384) % 2);
    if (fp > 0) checkOutput({ctx, " framerate"}, framerate, (k / fp) % 2);
`endif
  endtask

  task automatic applyStimulus(input int edges, input int hold_at, input int hold_len,
                               input string ctx, input int fp);
    for (int i = 1; i <= edges; i++) begin
      if (i == hold_at) enable = 1'b0;
      if (i == hold_at + hold_len) enable = 1'b1;
      step();
      checkCascade(ctx, fp);
    end
  endtask

  task automatic applyLoad(input int value);
    frame_period_in   = FRAME_W'(value);
    frame_period_load = 1'b1;
    step();
    frame_period_load = 1'b0;
  endtask

  task automatic restartPulse(input string ctx);
    restart = 1'b1;
    step();
    restart = 1'b0;
    checkCascade(ctx, 0);
    checkOutput({ctx, " frame_tick"}, frame_tick, 0);
  endtask

  task automatic waitFrame(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if (frame_tick === 1'b1) begin
        at = edge_no;
        break;
      end
    end
    checkOutput("frame_tick seen", 32'(at >= 0), 1);
  endtask

  int r0, t1, t2, t3, t4, t5, t6, t7, t8;

  initial begin
    reset = 1'b1; enable = 1'b1; restart = 1'b0;
    frame_period_in = '0; frame_period_load = 1'b0;
    repeat (3) step();

    checkOutput("reset seg_tick",     seg_tick, 0);
    checkOutput("reset bit_tick",     bit_tick, 0);
    checkOutput("reset led_tick",     led_tick, 0);
    checkOutput("reset frame_tick",   frame_tick, 0);
    checkOutput("reset seg_index",    seg_index, 0);
    checkOutput("reset bit_index",    bit_index, 0);
    checkOutput("reset frame_period", frame_period, P0);
    checkOutput("reset load_pending", load_pending, 0);

    // Free run from reset: seg every 4, bit every 16, LED at 384, frame at 600.
    reset = 1'b0;
    applyStimulus(610, 0, 0, "run", P0);

    // Enable low at edges 10..12: next seg_tick moves from edge 12 to edge 15.
    restartPulse("restart1");
    applyStimulus(20, 10, 3, "hold", 0);

    // Load 1000 mid-frame: applies after the next frame_tick.
    restartPulse("restart2");
    r0 = edge_no;
    applyStimulus(100, 0, 0, "pre", P0);
    applyLoad(1000);
    checkOutput("load1000 pending", load_pending, 1);
    checkOutput("load1000 old period", frame_period, P0);
    waitFrame(2000, t1);
    checkOutput("load1000 boundary", t1 - r0, P0);
    checkOutput("load1000 period", frame_period, 1000);
    checkOutput("load1000 pending clear", load_pending, 0);
    waitFrame(2000, t2);
    checkOutput("load1000 next frame", t2 - t1, 1000);

    // Load 0 clamps to 2.
    repeat (3) step();
    applyLoad(0);
    checkOutput("load0 pending", load_pending, 1);
    waitFrame(2000, t3);
    checkOutput("load0 boundary", t3 - t2, 1000);
    checkOutput("load0 clamped period", frame_period, 2);
    waitFrame(10, t4);
    checkOutput("period2 gap a", t4 - t3, 2);
    waitFrame(10, t5);
    checkOutput("period2 gap b", t5 - t4, 2);

    // Load coinciding with the wrap: old shadow applied, new one stays pending.
    step();
    applyLoad(50);
    checkOutput("wrapload frame_tick", frame_tick, 1);
    checkOutput("wrapload period", frame_period, 2);
    checkOutput("wrapload pending", load_pending, 1);
    waitFrame(10, t6);
    checkOutput("wrapload gap", t6 - (t5 + 2), 2);
    checkOutput("wrapload applied", frame_period, 50);
    checkOutput("wrapload pending clear", load_pending, 0);
    waitFrame(100, t7);
    checkOutput("period50 gap", t7 - t6, 50);

    // Restart at edge 7 with 500 pending: applied at once.
    restartPulse("restart3");
    repeat (2) step();
    applyLoad(500);
    checkOutput("load500 pending", load_pending, 1);
    repeat (3) step();
    restartPulse("restart4");
    checkOutput("restart4 period", frame_period, 500);
    checkOutput("restart4 pending", load_pending, 0);
    r0 = edge_no;
    applyStimulus(8, 0, 0, "after restart", 0);
    waitFrame(1000, t8);
    checkOutput("period500 first frame", t8 - r0, 500);

    // Restart with a load in the same cycle: the load is staged and applied.
    frame_period_in = FRAME_W'(700);
    frame_period_load = 1'b1;
    restartPulse("restart5");
    frame_period_load = 1'b0;
    checkOutput("restart5 period", frame_period, 700);
    checkOutput("restart5 pending", load_pending, 0);
    applyStimulus(40, 0, 0, "square", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
